// File: rtl/alu_serial_seq.sv
// Bit-serial ALU sequencer: streams WIDTH-bit operands LSB-first through an
// external 1-bit slice and collects its output into a right-shifting result.
module alu_serial_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_carry,
  output logic             out_zero,
  output logic [4:0]       slice_op,
  output logic             slice_a,
  output logic             slice_b,
  output logic             slice_cin,
  input  logic             slice_o,
  input  logic             slice_cout
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state;
  logic [4:0]       op_reg;
  logic [WIDTH-1:0] a_reg, b_reg, res_reg;
  logic             carry_reg;
  logic [CW-1:0]    cnt;
  logic             run;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      op_reg    <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      res_reg   <= '0;
      carry_reg <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        S_IDLE: if (in_valid) begin
          op_reg    <= in_op;
          a_reg     <= in_a;
          b_reg     <= in_b;
          carry_reg <= in_cin;
          res_reg   <= '0;
          cnt       <= '0;
          state     <= S_RUN;
        end
        S_RUN: begin
          a_reg     <= a_reg >> 1;
          b_reg     <= b_reg >> 1;
          carry_reg <= slice_cout;
          res_reg   <= {slice_o, res_reg[WIDTH-1:1]};
          // Counter parks at the last index so it never wraps.
          if (cnt == LAST) state <= S_DONE;
          else             cnt   <= cnt + 1'b1;
        end
        S_DONE: if (out_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign run        = (state == S_RUN);
  assign in_ready   = (state == S_IDLE);
  assign out_valid  = (state == S_DONE);
  assign out_result = res_reg;
  assign out_carry  = carry_reg;
  assign out_zero   = (res_reg == '0);

  assign slice_op  = run ? op_reg : 5'd0;
  assign slice_a   = run & a_reg[0];
  assign slice_b   = run & b_reg[0];
  assign slice_cin = run & carry_reg;

endmodule
